// File: rtl/layer_address_sequencer_pkg.sv
// Shared constants, types and power-up program for the layer address sequencer.
package layer_address_sequencer_pkg;

    localparam int unsigned IMEM_DEPTH = 16;
    localparam int unsigned IMEM_AW    = $clog2(IMEM_DEPTH);

    typedef logic [7:0] word_t;

    localparam word_t END_OF_PROGRAM     = 8'hFF;
    localparam word_t NEURO_RW_BASE_LOW  = 8'd0;
    localparam word_t NEURO_RW_BASE_HIGH = 8'd20;

    typedef enum logic [1:0] {StLoad, StFetch, StRun, StDone} state_e;

    localparam word_t DEFAULT_PROGRAM [IMEM_DEPTH] = '{
        0: 8'd2,
        1: 8'd3,
        2: 8'd2,
        default: END_OF_PROGRAM
    };

    // A zero-sized layer is treated the same as an explicit end marker.
    function automatic logic is_terminal(word_t v);
        return (v == END_OF_PROGRAM) || (v == 8'd0);
    endfunction

endpackage

// File: rtl/layer_address_sequencer_instr_mem.sv
// Layer-size program store: asynchronous read, synchronous write, preloaded at power-up.
module layer_address_sequencer_instr_mem
    import layer_address_sequencer_pkg::*;
(
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic [IMEM_AW-1:0] wr_addr_i,
    input  word_t              wr_data_i,
    input  logic [IMEM_AW-1:0] rd_addr_i,
    output word_t              rd_data_o
);

    // Deliberately reset-less so the program survives a sequencer reset.
    word_t mem_q [IMEM_DEPTH] = DEFAULT_PROGRAM;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/layer_address_sequencer.sv
// Steps through the layer-size program and issues per-cycle neuron/weight addresses for the MAC.
module layer_address_sequencer
    import layer_address_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_wr_en,
    input  logic [7:0] instr_wr_addr,
    input  logic [7:0] instr_wr_data,
    output logic [7:0] neuro_read_addr,
    output logic [7:0] weight_read_addr,
    output logic [7:0] neuro_write_addr,
    output logic       neuron_finished,
    output logic       layer_finished,
    output logic       alu_rst,
    output logic       program_finished,
    output logic [7:0] current_layer_size,
    output logic [7:0] previous_layer_size,
    output logic [7:0] result_base_address,
    output logic [7:0] result_word_count
);

    state_e state_q, state_d;
    word_t  ip_q, ip_d;
    word_t  i_q, i_d;
    word_t  j_q, j_d;
    word_t  w_q, w_d;
    word_t  prev_q, prev_d;
    word_t  cur_q, cur_d;
    word_t  rbase_q, rbase_d;
    word_t  rd_hold_q, rd_hold_d;
    word_t  wt_hold_q, wt_hold_d;
    word_t  wr_hold_q, wr_hold_d;

    word_t  imem_rd_data;
    word_t  fetch_word;
    word_t  rd_base;
    word_t  wr_base;
    logic   last_term;
    logic   last_neuron;
    logic   unused_wr_addr_hi;

    assign unused_wr_addr_hi = ^instr_wr_addr[7:IMEM_AW];

    // ip is 0 in LOAD, so one read port serves both the input-size and layer fetches.
    layer_address_sequencer_instr_mem u_instr_mem (
        .clk_i     (clk),
        .wr_en_i   (instr_wr_en),
        .wr_addr_i (instr_wr_addr[IMEM_AW-1:0]),
        .wr_data_i (instr_wr_data),
        .rd_addr_i (ip_q[IMEM_AW-1:0]),
        .rd_data_o (imem_rd_data)
    );

    assign fetch_word  = (ip_q >= 8'(IMEM_DEPTH)) ? END_OF_PROGRAM : imem_rd_data;
    assign rd_base     = ip_q[0] ? NEURO_RW_BASE_LOW : NEURO_RW_BASE_HIGH;
    assign wr_base     = ip_q[0] ? NEURO_RW_BASE_HIGH : NEURO_RW_BASE_LOW;
    assign last_term   = (i_q == prev_q - 8'd1);
    assign last_neuron = (j_q == cur_q - 8'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ip_q      <= 8'd0;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            w_q       <= 8'd0;
            prev_q    <= 8'd0;
            cur_q     <= 8'd0;
            rbase_q   <= NEURO_RW_BASE_HIGH;
            rd_hold_q <= 8'd0;
            wt_hold_q <= 8'd0;
            wr_hold_q <= 8'd0;
        end else begin
            ip_q      <= ip_d;
            i_q       <= i_d;
            j_q       <= j_d;
            w_q       <= w_d;
            prev_q    <= prev_d;
            cur_q     <= cur_d;
            rbase_q   <= rbase_d;
            rd_hold_q <= rd_hold_d;
            wt_hold_q <= wt_hold_d;
            wr_hold_q <= wr_hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        i_d       = i_q;
        j_d       = j_q;
        w_d       = w_q;
        prev_d    = prev_q;
        cur_d     = cur_q;
        rbase_d   = rbase_q;
        rd_hold_d = rd_hold_q;
        wt_hold_d = wt_hold_q;
        wr_hold_d = wr_hold_q;
        unique case (state_q)
            StLoad: begin
                prev_d  = fetch_word;
                ip_d    = 8'd1;
                w_d     = 8'd0;
                state_d = is_terminal(fetch_word) ? StDone : StFetch;
            end
            StFetch: begin
                cur_d   = fetch_word;
                i_d     = 8'd0;
                j_d     = 8'd0;
                state_d = is_terminal(fetch_word) ? StDone : StRun;
            end
            StRun: begin
                // Weight pointer runs on across layers: weights are packed back to back.
                w_d       = w_q + 8'd1;
                i_d       = i_q + 8'd1;
                rd_hold_d = rd_base + i_q;
                wt_hold_d = w_q;
                if (last_term) begin
                    i_d       = 8'd0;
                    j_d       = j_q + 8'd1;
                    wr_hold_d = wr_base + j_q;
                    if (last_neuron) begin
                        rbase_d = wr_base;
                        prev_d  = cur_q;
                        ip_d    = ip_q + 8'd1;
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_comb begin
        neuro_read_addr  = rd_hold_q;
        weight_read_addr = wt_hold_q;
        neuro_write_addr = wr_hold_q;
        neuron_finished  = 1'b0;
        layer_finished   = 1'b0;
        if (state_q == StRun) begin
            neuro_read_addr  = rd_base + i_q;
            weight_read_addr = w_q;
            neuron_finished  = last_term;
            layer_finished   = last_term && last_neuron;
            if (last_term) begin
                neuro_write_addr = wr_base + j_q;
            end
        end
    end

    assign alu_rst             = !reset || (state_q == StLoad);
    assign program_finished    = (state_q == StDone);
    assign current_layer_size  = (state_q == StDone) ? END_OF_PROGRAM : cur_q;
    assign previous_layer_size = prev_q;
    assign result_base_address = rbase_q;
    assign result_word_count   = prev_q;

endmodule

// File: tb/tb_layer_address_sequencer.sv
// Bench for layer_address_sequencer: per-cycle output trace compared against a layer-loop model.
module tb_layer_address_sequencer;

    typedef struct packed {
        logic [7:0] rd;
        logic [7:0] wt;
        logic [7:0] wr;
        logic       nf;
        logic       lf;
        logic       ar;
        logic       pf;
        logic [7:0] cur;
        logic [7:0] prev;
        logic [7:0] rb;
        logic [7:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       instr_wr_en = 1'b0;
    logic [7:0] instr_wr_addr = 8'd0;
    logic [7:0] instr_wr_data = 8'd0;
    logic [7:0] neuro_read_addr;
    logic [7:0] weight_read_addr;
    logic [7:0] neuro_write_addr;
    logic       neuron_finished;
    logic       layer_finished;
    logic       alu_rst;
    logic       program_finished;
    logic [7:0] current_layer_size;
    logic [7:0] previous_layer_size;
    logic [7:0] result_base_address;
    logic [7:0] result_word_count;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] prog [16];
    obs_t       exp_q [$];

    always #5 clk = ~clk;

    layer_address_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .instr_wr_en         (instr_wr_en),
        .instr_wr_addr       (instr_wr_addr),
        .instr_wr_data       (instr_wr_data),
        .neuro_read_addr     (neuro_read_addr),
        .weight_read_addr    (weight_read_addr),
        .neuro_write_addr    (neuro_write_addr),
        .neuron_finished     (neuron_finished),
        .layer_finished      (layer_finished),
        .alu_rst             (alu_rst),
        .program_finished    (program_finished),
        .current_layer_size  (current_layer_size),
        .previous_layer_size (previous_layer_size),
        .result_base_address (result_base_address),
        .result_word_count   (result_word_count)
    );

    function automatic obs_t mk(input logic [7:0] rd, input logic [7:0] wt, input logic [7:0] wr,
                                input logic nf, input logic lf, input logic ar, input logic pf,
                                input logic [7:0] cur, input logic [7:0] prev,
                                input logic [7:0] rb);
        obs_t o;
        o.rd   = rd;
        o.wt   = wt;
        o.wr   = wr;
        o.nf   = nf;
        o.lf   = lf;
        o.ar   = ar;
        o.pf   = pf;
        o.cur  = cur;
        o.prev = prev;
        o.rb   = rb;
        o.cnt  = prev;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.rd   = neuro_read_addr;
        o.wt   = weight_read_addr;
        o.wr   = neuro_write_addr;
        o.nf   = neuron_finished;
        o.lf   = layer_finished;
        o.ar   = alu_rst;
        o.pf   = program_finished;
        o.cur  = current_layer_size;
        o.prev = previous_layer_size;
        o.rb   = result_base_address;
        o.cnt  = result_word_count;
        return o;
    endfunction

    // Expected trace: one LOAD cycle, then per layer a FETCH cycle and prev*cur MAC terms.
    function automatic void build_model();
        logic [7:0] rd = 8'd0, wt = 8'd0, wr = 8'd0, rb = 8'd20;
        logic [7:0] prevs = 8'd0, curs = 8'd0, w = 8'd0, n, rbase, wbase;
        logic       nf, lf;
        int         ip = 1;
        exp_q.delete();
        exp_q.push_back(mk(rd, wt, wr, 1'b0, 1'b0, 1'b1, 1'b0, curs, prevs, rb));
        prevs = prog[0];
        if (prevs != 8'd0 && prevs != 8'hFF) begin
            while (1) begin
                n = (ip < 16) ? prog[ip] : 8'hFF;
                exp_q.push_back(mk(rd, wt, wr, 1'b0, 1'b0, 1'b0, 1'b0, curs, prevs, rb));
                if (n == 8'd0 || n == 8'hFF) break;
                curs  = n;
                rbase = (ip % 2 == 1) ? 8'd0 : 8'd20;
                wbase = (ip % 2 == 1) ? 8'd20 : 8'd0;
                for (int j = 0; j < int'(n); j++) begin
                    for (int i = 0; i < int'(prevs); i++) begin
                        rd = rbase + 8'(i);
                        wt = w;
                        nf = (i == int'(prevs) - 1);
                        lf = nf && (j == int'(n) - 1);
                        if (nf) wr = wbase + 8'(j);
                        exp_q.push_back(mk(rd, wt, wr, nf, lf, 1'b0, 1'b0, curs, prevs, rb));
                        w = w + 8'd1;
                    end
                end
                rb    = wbase;
                prevs = n;
                ip++;
            end
        end
        repeat (3) exp_q.push_back(mk(rd, wt, wr, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, prevs, rb));
    endfunction

    task automatic check(input string tag, input int c, input obs_t expv);
        obs_t got;
        got = observe();
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, got, expv);
        end
    endtask

    task automatic run_program(input string tag, input bit do_write, input int reset_at);
        int c;
        bit replayed;
        build_model();
        @(negedge clk);
        reset = 1'b0;
        if (do_write) begin
            for (int k = 0; k < 16; k++) begin
                instr_wr_en   = 1'b1;
                instr_wr_addr = {4'($urandom_range(0, 15)), 4'(k)};
                instr_wr_data = prog[k];
                @(negedge clk);
            end
        end
        instr_wr_en = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        c        = 0;
        replayed = 1'b0;
        while (c < exp_q.size()) begin
            check(tag, c, exp_q[c]);
            if (c == reset_at && !replayed) begin
                reset = 1'b0;
                @(negedge clk);
                check({tag, "_midreset"}, c, exp_q[0]);
                reset    = 1'b1;
                replayed = 1'b1;
                c        = 0;
            end else begin
                @(negedge clk);
                c++;
            end
        end
    endtask

    initial begin
        int nl;

        prog = '{0: 8'd2, 1: 8'd3, 2: 8'd2, default: 8'hFF};
        run_program("powerup_default", 1'b0, -1);

        run_program("reset_at_5", 1'b0, 5);

        prog = '{0: 8'd3, 1: 8'd1, default: 8'hFF};
        run_program("prog_3_1", 1'b1, -1);

        prog = '{0: 8'd4, default: 8'hFF};
        run_program("prog_4", 1'b1, -1);

        prog = '{0: 8'd2, 1: 8'd3, 2: 8'd1, default: 8'hFF};
        run_program("entry2_is_1", 1'b1, -1);

        prog = '{0: 8'd0, 1: 8'd3, 2: 8'd2, default: 8'hFF};
        run_program("input_size_0", 1'b1, -1);

        prog = '{0: 8'd2, 1: 8'd0, default: 8'hFF};
        run_program("layer_size_0", 1'b1, -1);

        prog = '{default: 8'd1};
        run_program("ip_overflow", 1'b1, -1);

        for (int t = 0; t < 6; t++) begin
            prog    = '{default: 8'hFF};
            prog[0] = 8'($urandom_range(1, 4));
            nl      = int'($urandom_range(1, 4));
            for (int k = 1; k <= nl; k++) prog[k] = 8'($urandom_range(1, 4));
            run_program("random", 1'b1, (t % 2 == 0) ? int'($urandom_range(2, 8)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
